// File: rtl/mem_bus_sequencer.sv
// Multi-cycle fetch/data sequencer between the MIPS core and one Avalon-style memory port.
// Latency: 3 cycles per instruction, 4 with a data access, +1 per waitrequest cycle; stalls on mem_waitrequest.
// Backpressure: address/strobes held while mem_waitrequest=1; MAX_WAIT stalled cycles trip a sticky bus_error and HALT.
module mem_bus_sequencer #(
    parameter logic [7:0] MAX_WAIT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_out,
    output logic [31:0] instr,
    output logic [31:0] data_in,
    output logic        clock_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DATA,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_in_q, data_in_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        clock_enable_q, clock_enable_d;
    logic        bus_error_q, bus_error_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout;

    // Compare in 9 bits so the incremented count never wraps below MAX_WAIT.
    assign timeout = (MAX_WAIT != 8'd0) &&
                     (({1'b0, wait_cnt_q} + 9'd1) >= {1'b0, MAX_WAIT});

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        data_in_d       = data_in_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        clock_enable_d  = 1'b0;
        bus_error_d     = bus_error_q;
        wait_cnt_d      = wait_cnt_q;

        case (state_q)
            S_IDLE, S_EXEC: begin
                if (cpu_active) begin
                    state_d       = S_FETCH;
                    mem_address_d = {cpu_pc[31:2], 2'b00};
                    mem_read_d    = 1'b1;
                    wait_cnt_d    = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_waitrequest) begin
                    if (timeout) begin
                        state_d     = S_HALT;
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        bus_error_d = 1'b1;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else if (state_q == S_FETCH) begin
                    state_d    = S_DECODE;
                    instr_d    = mem_readdata;
                    mem_read_d = 1'b0;
                end else begin
                    if (mem_read_q) begin
                        data_in_d = mem_readdata;
                    end
                    state_d        = S_EXEC;
                    mem_read_d     = 1'b0;
                    mem_write_d    = 1'b0;
                    clock_enable_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (cpu_data_read) begin
                    state_d       = S_DATA;
                    mem_address_d = {cpu_data_address[31:2], 2'b00};
                    mem_read_d    = 1'b1;
                    wait_cnt_d    = 8'd0;
                end else if (cpu_data_write) begin
                    state_d         = S_DATA;
                    mem_address_d   = {cpu_data_address[31:2], 2'b00};
                    mem_write_d     = 1'b1;
                    mem_writedata_d = cpu_data_out;
                    wait_cnt_d      = 8'd0;
                end else begin
                    state_d        = S_EXEC;
                    clock_enable_d = 1'b1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d     = S_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            instr_q         <= 32'd0;
            data_in_q       <= 32'd0;
            mem_address_q   <= 32'd0;
            mem_writedata_q <= 32'd0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            clock_enable_q  <= 1'b0;
            bus_error_q     <= 1'b0;
            wait_cnt_q      <= 8'd0;
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            data_in_q       <= data_in_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            clock_enable_q  <= clock_enable_d;
            bus_error_q     <= bus_error_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

    assign instr          = instr_q;
    assign data_in        = data_in_q;
    assign clock_enable   = clock_enable_q;
    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = 4'hF;
    assign bus_error      = bus_error_q;

endmodule
